// File: rtl/add_iter.sv
// Multi-cycle ripple adder: adds one CHUNK-bit slice of A+B per clock and reports condition flags.
// Define SUB_MODE_EN to add the sub_op port and enable A-B.
module add_iter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SUB_MODE_EN
  input  logic             sub_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin;

  logic             sub_c;
  int unsigned      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sl_sum;
  logic [WIDTH-1:0] s_new;
  logic             c_msb;

`ifdef SUB_MODE_EN
  assign sub_c = sub_op;
`else
  assign sub_c = 1'b0;
`endif

  // Current slice add; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    base   = 32'(idx) * CHUNK;
    a_sl   = a_r[base +: CHUNK];
    b_sl   = b_r[base +: CHUNK];
    sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cin};
    s_new  = S;
    s_new[base +: CHUNK] = sl_sum[CHUNK-1:0];
    c_msb  = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ s_new[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      cin      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      S        <= '0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A;
            b_r   <= sub_c ? ~B : B;
            cin   <= sub_c;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          S   <= s_new;
          cin <= sl_sum[CHUNK];
          idx <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            carry    <= sl_sum[CHUNK];
            overflow <= c_msb ^ sl_sum[CHUNK];
            zero     <= (s_new == '0);
            sign     <= s_new[WIDTH-1];
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_iter.sv
// Self-checking bench for add_iter against an arithmetic reference model.
module tb_add_iter;

  localparam int unsigned W = 64;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
`ifdef SUB_MODE_EN
  logic         sub_op = 1'b0;
`endif
  logic         busy, done, overflow, carry, zero, sign;
  logic [W-1:0] S;

  int nvec = 0;
  int nerr = 0;

  add_iter #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
`ifdef SUB_MODE_EN
    .sub_op(sub_op),
`endif
    .busy(busy), .done(done), .S(S), .overflow(overflow),
    .carry(carry), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference result from plain two's-complement arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] es, output logic ec, output logic eov);
    logic [W:0] wide;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b};
      es   = wide[W-1:0];
      ec   = wide[W];
      eov  = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
    end else begin
      es  = a - b;
      ec  = (a >= b);
      eov = (a[W-1] != b[W-1]) && (es[W-1] != a[W-1]);
    end
  endtask

  // Waits (bounded) for done from #1 after the accepting edge; returns edges elapsed.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub);
    logic [W-1:0] es;
    logic ec, eov;
    model(a, b, sub, es, ec, eov);
    nvec++;
    if (S !== es || carry !== ec || overflow !== eov || zero !== (es == '0) || sign !== es[W-1]) begin
      nerr++;
      $display("FAIL %s: got S=%h c=%b ov=%b z=%b s=%b, want S=%h c=%b ov=%b z=%b s=%b",
               nm, S, carry, overflow, zero, sign, es, ec, eov, es == '0, es[W-1]);
    end
  endtask

  // Full operation from #1 after a posedge; scrambles A/B while busy.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
    int lat, bc;
    A = a; B = b; start = 1'b1;
`ifdef SUB_MODE_EN
    sub_op = sub;
`endif
    @(posedge clk); #1;
    start = 1'b0; A = rnd64(); B = rnd64();
`ifdef SUB_MODE_EN
    sub_op = ~sub;
`endif
    wait_done(lat, bc);
    nvec++;
    if (lat != N || bc != N + 1) begin
      nerr++;
      $display("FAIL %s latency: got lat=%0d busy_cycles=%0d, want %0d/%0d", nm, lat, bc, N, N + 1);
    end
    check_result(nm, a, b, sub);
    @(posedge clk); #1;
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s pulse: got done=%b busy=%b, want 0/0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || overflow !== 1'b0 || carry !== 1'b0 ||
        zero !== 1'b0 || sign !== 1'b0) begin
      nerr++;
      $display("FAIL reset: got busy=%b done=%b S=%h ov=%b c=%b z=%b s=%b, want all 0",
               busy, done, S, overflow, carry, zero, sign);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] v;
    run_op("add_5_7", 64'd5, 64'd7, 1'b0);
    v = 64'h7FFF_FFFF_FFFF_FFFF;
    run_op("add_ovf", v, 64'd1, 1'b0);
    v = 64'hFFFF_FFFF_FFFF_FFFF;
    run_op("add_wrap", v, 64'd1, 1'b0);
    run_op("add_zero", 64'd0, 64'd0, 1'b0);
    v = 64'h8000_0000_0000_0000;
    run_op("add_neg_ovf", v, v, 1'b0);
`ifdef SUB_MODE_EN
    run_op("sub_3_3", 64'd3, 64'd3, 1'b1);
    run_op("sub_ovf", v, 64'd1, 1'b1);
    run_op("sub_borrow", 64'd1, 64'd2, 1'b1);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic sub;
`ifdef SUB_MODE_EN
      sub = 1'($urandom_range(1));
`else
      sub = 1'b0;
`endif
      run_op("random", rnd64(), rnd64(), sub);
    end
  endtask

  // start held high with new operands: first result intact, one done, next op only from IDLE.
  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int dones, lat, bc;
    a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
    A = a1; B = b1; start = 1'b1;
`ifdef SUB_MODE_EN
    sub_op = 1'b0;
`endif
    @(posedge clk); #1;
    A = a2; B = b2;
    dones = 0;
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check_result("held_first", a1, b1, 1'b0);
      end
    end
    nvec++;
    if (dones != 1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL held_done_count: got dones=%0d busy=%b, want 1/0", dones, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL held_reaccept: got busy=%b, want 1", busy);
    end
    wait_done(lat, bc);
    nvec++;
    if (lat != N) begin
      nerr++;
      $display("FAIL held_second_lat: got %0d, want %0d", lat, N);
    end
    check_result("held_second", a2, b2, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones;
    A = rnd64() | 64'h1; B = rnd64(); start = 1'b1;
`ifdef SUB_MODE_EN
    sub_op = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    nvec++;
    if (dones != 0) begin
      nerr++;
      $display("FAIL reset_abort: got %0d busy/done cycles, want 0", dones);
    end
    run_op("after_reset", 64'd100, 64'd23, 1'b0);
  endtask

  initial begin
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
